// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU: one quotient bit per cycle, result {rem, quo}.
// Build option: define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              signed_div_i,
   input  logic [XLEN-1:0]   opdata1_i,
   input  logic [XLEN-1:0]   opdata2_i,
   input  logic              start_i,
   input  logic              annul_i,
   output logic [2*XLEN-1:0] result_o,
   output logic              ready_o,
   output logic [1:0]        dbg_state
);

   // Handshake: EX raises start_i and holds it until it sees ready_o; result_o is
   // valid while ready_o=1. Dropping start_i returns the FSM to IDLE. annul_i wins
   // over start_i in every state.
   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_DIV, S_DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   dvd;    // dividend bits shift out, quotient bits shift in
   logic [XLEN-1:0]   dvs;
   logic [XLEN-1:0]   rem;
   logic              neg_q;
   logic              neg_r;
   logic [2*XLEN-1:0] res;

   logic [XLEN-1:0]   a_abs;
   logic [XLEN-1:0]   b_abs;
   logic [XLEN+1:0]   trial;
   logic [XLEN-1:0]   rem_nx;
   logic [XLEN-1:0]   quo_nx;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;

   assign a_abs = (signed_div_i && opdata1_i[XLEN-1]) ? -opdata1_i : opdata1_i;
   assign b_abs = (signed_div_i && opdata2_i[XLEN-1]) ? -opdata2_i : opdata2_i;

   // Extra top bit of trial is the borrow: set means the subtraction went negative.
   assign trial  = {1'b0, rem, dvd[XLEN-1]} - {2'b00, dvs};
   assign rem_nx = trial[XLEN+1] ? {rem[XLEN-2:0], dvd[XLEN-1]} : trial[XLEN-1:0];
   assign quo_nx = {dvd[XLEN-2:0], ~trial[XLEN+1]};
   assign q_fix  = neg_q ? -quo_nx : quo_nx;
   assign r_fix  = neg_r ? -rem_nx : rem_nx;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         res      <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready_o <= 1'b0;
               if (start_i && !annul_i) begin
                  cnt   <= '0;
                  dvd   <= a_abs;
                  dvs   <= b_abs;
                  rem   <= '0;
                  neg_q <= signed_div_i && (opdata1_i[XLEN-1] ^ opdata2_i[XLEN-1]);
                  neg_r <= signed_div_i && opdata1_i[XLEN-1];
                  if (opdata2_i == '0) begin
                     res   <= {opdata1_i, {XLEN{1'b1}}};
                     state <= S_BYZERO;
                  end
`ifdef DIV_EARLY_OUT_EN
                  else if (a_abs < b_abs) begin
                     res   <= {opdata1_i, {XLEN{1'b0}}};
                     state <= S_DONE;
                  end
`endif
                  else begin
                     state <= S_DIV;
                  end
               end
            end
            S_BYZERO: begin
               if (annul_i || !start_i) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else begin
                  state <= S_DONE;
               end
            end
            S_DIV: begin
               if (annul_i || !start_i) begin
                  state    <= S_IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else begin
                  dvd <= quo_nx;
                  rem <= rem_nx;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1)) begin
                     res   <= {r_fix, q_fix};
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (annul_i || !start_i) begin
                  state   <= S_IDLE;
                  ready_o <= 1'b0;
               end else begin
                  ready_o  <= 1'b1;
                  result_o <= res;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: vector table of {mode, operands, quotient, remainder} plus abort/reset sequences.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   div_seq #(.XLEN(32), .CNT_W(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        scr;
   } vec_t;

   vec_t tv[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic sd, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] aa;
      logic [31:0] bb;
      aa = (sd && a[31]) ? -a : a;
      bb = (sd && b[31]) ? -b : b;
      if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
      if (aa < bb) return 1;
`endif
      return 33;
   endfunction

   // Drives one operation, measures edges from acceptance to ready_o, then releases start.
   task automatic run_op(input string name, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                         input logic scr);
      int k;
      int lat;
      @(negedge clk);
      signed_div_i = sd;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      @(posedge clk); #1;
      chk({name, " ready@N"}, {63'd0, ready_o}, 64'd0);
      if (scr) begin
         opdata1_i    = $urandom;
         opdata2_i    = $urandom;
         signed_div_i = ~sd;
      end
      k = 0;
      while (!ready_o && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      lat = ready_o ? k : -1;
      chk({name, " latency"}, 64'(lat), 64'(exp_lat(sd, a, b)));
      chk({name, " result"}, result_o, {r, q});
      @(posedge clk); #1;
      chk({name, " hold"}, {ready_o, result_o[31:0]}, {1'b1, q});
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk({name, " release"}, {63'd0, ready_o}, 64'd0);
      chk({name, " kept"}, result_o, {r, q});
   endtask

   // Starts an unsigned 100/7 and leaves it running n edges past acceptance.
   task automatic start_div(input int n);
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      int seen;
      int k;
      tv[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
      tv[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
      tv[2]  = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
      tv[3]  = '{1'b1, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      1'b0};
      tv[4]  = '{1'b0, 32'h1234,      32'd0,         32'hFFFF_FFFF, 32'h1234,      1'b0};
      tv[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
      tv[6]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3,         1'b0};
      tv[7]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
      tv[8]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
      tv[9]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0};
      tv[10] = '{1'b0, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2,         1'b1};
      tv[11] = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b1};
      tv[12] = '{1'b1, 32'd3,         32'hFFFF_FFF6, 32'd0,         32'd3,         1'b0};
      tv[13] = '{1'b1, 32'hFFFF_FFFD, 32'd10,        32'd0,         32'hFFFF_FFFD, 1'b0};

      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'd0; opdata2_i = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset outputs", {result_o[62:0], ready_o}, 64'd0);
      chk("reset state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 14; i++)
         run_op($sformatf("vec%0d", i), tv[i].sd, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].scr);

      // annul wins over start while idle
      @(negedge clk);
      start_i = 1'b1; annul_i = 1'b1; opdata2_i = 32'd7;
      @(posedge clk); #1;
      chk("annul idle state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      start_i = 1'b0; annul_i = 1'b0;

      // annul pulse ten cycles into the division
      start_div(10);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1;
      chk("annul div ready", {63'd0, ready_o}, 64'd0);
      chk("annul div result", result_o, 64'd0);
      chk("annul div state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (ready_o) seen++;
      end
      chk("annul no ready", 64'(seen), 64'd0);
      run_op("after annul", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);

      // start dropped mid-division aborts and clears result
      start_div(5);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk("drop div", {result_o[62:0], ready_o}, 64'd0);

      // annul while waiting in BYZERO
      run_op("pre byzero", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
      @(posedge clk); #1;
      chk("byzero state", 64'(dbg_state), 64'd1);
      annul_i = 1'b1;
      @(posedge clk); #1;
      chk("byzero annul", {result_o[62:0], ready_o}, 64'd0);
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;

      // annul in DONE keeps the result but drops ready
      start_div(0);
      k = 0;
      while (!ready_o && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      chk("done ready", {63'd0, ready_o}, 64'd1);
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk); #1;
      chk("done annul ready", {63'd0, ready_o}, 64'd0);
      chk("done annul result", result_o, {32'd2, 32'd14});
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;

      // synchronous reset mid-division
      start_div(5);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst mid div", {result_o[62:0], ready_o}, 64'd0);
      chk("rst mid state", 64'(dbg_state), 64'd0);
      @(negedge clk);
      rst = 1'b0; start_i = 1'b0;
      run_op("after rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
